// File: rtl/token_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : token_arb_pkg
// Brief    : Shared width helpers and constants for the token FIFO arbiter.
// Revision : 1.0
// ============================================================================
package token_arb_pkg;

  localparam int c_RR_RESET_PTR = 0;

  // Ceiling log2, never below 1 so that single-bit fields stay legal.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int id_w(input int nreq);
    return clog2(nreq);
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/token_fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : token_fifo_rr_arbiter_if
// Brief    : Requester/consumer bundle of the shared token FIFO arbiter.
// Revision : 1.0
// ============================================================================
interface token_fifo_rr_arbiter_if #(
  parameter int NREQ = 4
);
  import token_arb_pkg::*;

  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] GNT;
  logic            CLR;
  logic            DEQ;
  logic            EMPTY_N;
  logic            FULL_N;
  logic [ID_W-1:0] OWNER;
  logic            DEQ_ERR;

  modport master (
    output REQ, CLR, DEQ,
    input  GNT, EMPTY_N, FULL_N, OWNER, DEQ_ERR
  );

  modport slave (
    input  REQ, CLR, DEQ,
    output GNT, EMPTY_N, FULL_N, OWNER, DEQ_ERR
  );

endinterface
`default_nettype wire

// File: rtl/token_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : token_arb_rr_pick
// Brief    : Combinational rotate-priority encoder starting at i_rr_ptr.
// Revision : 1.0
// ============================================================================
module token_arb_rr_pick
  import token_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_rr_ptr,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any_gnt
);

  // Position k places after the pointer, wrapped into 0..NREQ-1.
  function automatic int wrap_pos(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NREQ) ? (s - NREQ) : s;
  endfunction

  always_comb begin
    o_gnt     = '0;
    o_idx     = '0;
    o_any_gnt = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_enable && !o_any_gnt && i_req[wrap_pos(int'(i_rr_ptr), k)]) begin
        o_gnt[wrap_pos(int'(i_rr_ptr), k)] = 1'b1;
        o_idx     = ID_W'(wrap_pos(int'(i_rr_ptr), k));
        o_any_gnt = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/token_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : token_fifo_rr_arbiter
// Brief    : Round-robin shared token FIFO recording the owner of each token.
//            Optional macro TOKEN_ARB_FULL_BYPASS_EN allows enqueue into a
//            full FIFO when the head is dequeued in the same cycle.
// Revision : 1.0
// ============================================================================
module token_fifo_rr_arbiter
  import token_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 2,
  parameter bit GUARDED = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  token_fifo_rr_arbiter_if.slave bus
);

  localparam int                ID_W      = id_w(NREQ);
  localparam int                PTR_W     = ptr_w(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_DEPTH   = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0]   c_LAST_ID = ID_W'(NREQ - 1);
  localparam logic [ID_W-1:0]   c_RR_RST  = ID_W'(c_RR_RESET_PTR);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_tag [DEPTH];
  logic             r_empty_n;
  logic             r_full_n;
  logic             r_deq_err;
  logic             w_enq_ok;
  logic             w_enq;
  logic             w_deq;
  logic             w_deq_err;
  logic [NREQ-1:0]  w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;

`ifdef TOKEN_ARB_FULL_BYPASS_EN
  // A full FIFO whose head leaves this cycle can take the new token in place.
  assign w_enq_ok = RST_N & ~bus.CLR & (r_full_n | bus.DEQ);
`else
  assign w_enq_ok = RST_N & ~bus.CLR & r_full_n;
`endif

  assign w_deq     = bus.DEQ & r_empty_n & ~bus.CLR;
  assign w_deq_err = bus.DEQ & ~r_empty_n & ~bus.CLR;

  token_arb_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_req     (bus.REQ),
    .i_rr_ptr  (r_rr_ptr),
    .i_enable  (w_enq_ok),
    .o_gnt     (w_gnt),
    .o_idx     (w_gnt_idx),
    .o_any_gnt (w_enq)
  );

  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rr_ptr  <= c_RR_RST;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
      r_deq_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else if (bus.CLR) begin
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rr_ptr  <= c_RR_RST;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
      r_deq_err <= 1'b0;
    end else begin
      if (w_enq) begin
        r_tag[r_wr_ptr] <= w_gnt_idx;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_rr_ptr        <= (w_gnt_idx == c_LAST_ID) ? '0 : (w_gnt_idx + ID_W'(1));
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_empty_n <= (w_count_nxt != '0);
      r_full_n  <= (w_count_nxt != c_DEPTH);
      r_deq_err <= w_deq_err;
    end
  end

  assign bus.GNT     = w_gnt;
  assign bus.EMPTY_N = r_empty_n;
  assign bus.FULL_N  = r_full_n;
  assign bus.OWNER   = r_tag[r_rd_ptr];
  assign bus.DEQ_ERR = r_deq_err;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(w_gnt));
  a_guarded_full: assert property (@(posedge CLK) disable iff (!RST_N || !GUARDED)
                                   !(w_enq && (r_count == c_DEPTH)));
`endif

endmodule
`default_nettype wire

// File: doc/token_fifo_rr_arbiter.md
Name: token_fifo_rr_arbiter

Overview:
- Shares one zero-width token FIFO (occupancy-only queue, FIFO20 semantics generalised to DEPTH) among NREQ requesters.
- Round-robin arbitration picks at most one enqueue per cycle.
- Records the requester ID of every queued token, so the consumer sees the owner of the head token on dequeue.
- Sits between request sources (e.g. per-port credit returns) and a single shared consumer.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DEPTH, 2, token FIFO depth (power of two, >=2).
- guarded, 1, when 1, ENQ into a full FIFO is flagged even if DEQ is asserted in the same cycle (simulation check only).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester enqueue request, level; held until granted.
- GNT  out  NREQ  one-hot grant, combinational; GNT[i]=1 means the token from i is enqueued at this edge.
- CLR  in  1  synchronous flush.
- DEQ  in  1  consumer dequeue of the head token.
- EMPTY_N  out  1  FIFO holds >=1 token.
- FULL_N  out  1  FIFO has >=1 free slot.
- OWNER  out  clog2(NREQ)  requester ID of head token; valid only when EMPTY_N=1.
- DEQ_ERR  out  1  registered one-cycle pulse, DEQ seen while empty.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - count=0, EMPTY_N=0, FULL_N=1.
  - rr_ptr=0, wr_ptr=rd_ptr=0.
  - DEQ_ERR=0, OWNER=0.
  - GNT forced 0 while RST_N=0.
- Grant eligibility (enq_ok): FULL_N=1, CLR=0 and RST_N=1.
- Grant selection:
  - If enq_ok, grant the first asserted REQ searching rr_ptr, rr_ptr+1, ..., wrapping mod NREQ.
  - No REQ asserted or enq_ok=0 → GNT=0.
- rr_ptr update: after a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr is unchanged.
- Enqueue: tag[wr_ptr] <= i; wr_ptr <= wr_ptr+1 mod DEPTH.
- Dequeue: effective only when EMPTY_N=1; rd_ptr <= rd_ptr+1 mod DEPTH. DEQ while empty is ignored and pulses DEQ_ERR next cycle.
- Count update:
  - enq only: +1
  - deq only: -1
  - both: unchanged
- Flags: FULL_N and EMPTY_N are registered, derived from next count.
  - FULL_N = (count != DEPTH)
  - EMPTY_N = (count != 0)
- OWNER = tag[rd_ptr], registered path. Latency from enqueue into an empty FIFO to EMPTY_N=1 and a valid OWNER is 1 cycle.
- Full with DEQ in the same cycle: no grant (guarded behaviour); the slot frees next cycle.
- CLR=1:
  - Next edge: count=0, wr_ptr=rd_ptr=0, EMPTY_N=0, FULL_N=1, rr_ptr=0.
  - GNT=0 in the CLR cycle; DEQ ignored, no DEQ_ERR.
- Reset mid-operation: all state drops to reset values immediately; queued tokens are lost.
- Simulation checks (translate_off):
  - $display warning on DEQ while empty.
  - $display warning if GNT is not one-hot-or-zero.

Optional Feature:
- Macro: TOKEN_ARB_FULL_BYPASS_EN.
- Defined: when count==DEPTH and DEQ=1 (and CLR=0), enq_ok=1.
  - Grant proceeds; the simultaneous enq and deq keep count at DEPTH and FULL_N=0.
  - Tag is written into the slot freed by rd_ptr.
- Undefined: strictly guarded; a grant requires FULL_N=1.

Decomposition:
- Package token_arb_pkg holds:
  - function clog2
  - localparam ID_W = clog2(NREQ) and PTR_W = clog2(DEPTH), as parameterised helpers
  - constant RR_RESET_PTR = 0
- Sub-module token_arb_rr_pick: purely combinational rotate-priority encoder.
  - Inputs: REQ, rr_ptr, enable.
  - Outputs: one-hot GNT, granted index, any_gnt.
- The occupancy/tag store stays in the top module.

Test Plan:
- Reset then idle: EMPTY_N=0, FULL_N=1, GNT=0. Assert REQ=4'b0001 → GNT=0001; next cycle EMPTY_N=1, OWNER=0.
- Fairness: REQ=4'b1111 held, DEQ=1 every cycle once EMPTY_N=1 → grant order 0,1,2,3,0; OWNER sequence matches one cycle behind.
- Full (DEPTH=2):
  - REQ=4'b0110, DEQ=0 → grants 1 then 2; FULL_N=0; third cycle GNT=0.
  - Then DEQ=1 → OWNER=1 popped, FULL_N=1 next cycle, grant resumes at 1.
- Full with DEQ (macro off): count=2, REQ=4'b1000, DEQ=1 → GNT=0 that cycle, GNT=1000 the following cycle. With macro on: GNT=1000 in the same cycle, count stays 2.
- DEQ while empty: DEQ=1, EMPTY_N=0 → DEQ_ERR=1 for exactly one cycle; count stays 0.
- CLR and async reset:
  - With count=2, CLR=1 with REQ=4'b0001 → GNT=0; next cycle EMPTY_N=0, FULL_N=1.
  - RST_N pulled low mid-cycle → EMPTY_N=0 and GNT=0 immediately, without waiting for CLK.
